// File: rtl/id_stage.sv
// id_stage: MIPS decode/operand-read stage with a 32x32 GPR file and a
// busy-bit scoreboard that stalls issue on RAW and WAW hazards.
// Optional macro ID_STAGE_BYPASS_EN: treat a register written back this
// cycle as ready and forward wb_data into the operands.
module id_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instruction,
    output logic [DATA_WIDTH-1:0] out_regA,
    output logic [DATA_WIDTH-1:0] out_regB,
    output logic [4:0]            out_dest,
    output logic                  out_wen,
    input  logic                  wb_en,
    input  logic [4:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush
);

    logic [DATA_WIDTH-1:0] gpr_q [32];
    logic [DATA_WIDTH-1:0] gpr_d [32];
    logic [31:0]           busy_q, busy_d;

    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_instr_q, out_instr_d;
    logic [DATA_WIDTH-1:0] out_rega_q, out_rega_d;
    logic [DATA_WIDTH-1:0] out_regb_q, out_regb_d;
    logic [4:0]            out_dest_q, out_dest_d;
    logic                  out_wen_q, out_wen_d;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic [4:0] dec_dest;
    logic       dec_wen, use_rs, use_rt;
    logic       rs_fwd, rt_fwd, hazard, accept, wb_hit;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    assign opcode = in_instr[31:26];
    assign rs     = in_instr[25:21];
    assign rt     = in_instr[20:16];
    assign rd     = in_instr[15:11];
    assign funct  = in_instr[5:0];
    assign wb_hit = wb_en && (wb_addr != 5'd0);

    // Decode destination and which source fields the instruction actually reads.
    always_comb begin
        dec_dest = 5'd0;
        dec_wen  = 1'b0;
        use_rs   = 1'b1;
        use_rt   = 1'b0;
        case (opcode)
            6'b000000: begin
                dec_dest = rd;
                dec_wen  = 1'b1;
                use_rt   = 1'b1;
                // shifts by immediate take their operand from rt only
                if (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011)
                    use_rs = 1'b0;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b100011: begin
                dec_dest = rt;
                dec_wen  = 1'b1;
            end
            6'b101011, 6'b000100, 6'b000101: use_rt = 1'b1;
            default: ;
        endcase
        // a write to $0 is no write at all
        if (dec_dest == 5'd0) dec_wen = 1'b0;
        if (!dec_wen) dec_dest = 5'd0;
    end

    // Same-cycle writeback forwarding of source operands.
    always_comb begin
`ifdef ID_STAGE_BYPASS_EN
        rs_fwd = wb_hit && (wb_addr == rs);
        rt_fwd = wb_hit && (wb_addr == rt);
`else
        rs_fwd = 1'b0;
        rt_fwd = 1'b0;
`endif
        rd_a = (rs == 5'd0) ? '0 : (rs_fwd ? wb_data : gpr_q[rs]);
        rd_b = (rt == 5'd0) ? '0 : (rt_fwd ? wb_data : gpr_q[rt]);
    end

    assign hazard   = (use_rs && busy_q[rs] && !rs_fwd)
                    || (use_rt && busy_q[rt] && !rt_fwd)
                    || (dec_wen && busy_q[dec_dest]);
    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // Next-state for output register, scoreboard and register file.
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_rega_d  = out_rega_q;
        out_regb_d  = out_regb_q;
        out_dest_d  = out_dest_q;
        out_wen_d   = out_wen_q;
        busy_d      = busy_q;
        gpr_d       = gpr_q;

        if (wb_hit) begin
            gpr_d[wb_addr]  = wb_data;
            busy_d[wb_addr] = 1'b0;
        end
        // a squashed producer will never write back, so release its dest
        if (flush && out_valid_q && out_wen_q)
            busy_d[out_dest_q] = 1'b0;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = in_instr;
            out_rega_d  = rd_a;
            out_regb_d  = rd_b;
            out_dest_d  = dec_dest;
            out_wen_d   = dec_wen;
            // set after the writeback clear so a same-cycle set wins
            if (dec_wen) busy_d[dec_dest] = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_rega_q  <= '0;
            out_regb_q  <= '0;
            out_dest_q  <= '0;
            out_wen_q   <= 1'b0;
            busy_q      <= '0;
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_rega_q  <= out_rega_d;
            out_regb_q  <= out_regb_d;
            out_dest_q  <= out_dest_d;
            out_wen_q   <= out_wen_d;
            busy_q      <= busy_d;
            for (int i = 0; i < 32; i++) gpr_q[i] <= gpr_d[i];
        end
    end

    assign out_valid       = out_valid_q;
    assign out_instruction = out_instr_q;
    assign out_regA        = out_rega_q;
    assign out_regB        = out_regb_q;
    assign out_dest        = out_dest_q;
    assign out_wen         = out_wen_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, issue, RAW/WAW stalls, backpressure,
// flush, zero register, pass-through of unlisted opcodes.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr;
    logic        out_valid, out_ready;
    logic [31:0] out_instruction, out_regA, out_regB;
    logic [4:0]  out_dest;
    logic        out_wen;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADD3  = 32'h00221820; // add $3,$1,$2
    localparam logic [31:0] ADDI4 = 32'h20040005; // addi $4,$0,5
    localparam logic [31:0] SUB5  = 32'h00812822; // sub $5,$4,$1
    localparam logic [31:0] SW12  = 32'hAC410000; // sw $1,0($2)
    localparam logic [31:0] LW6   = 32'h8C260000; // lw $6,0($1)
    localparam logic [31:0] ADD7  = 32'h00C63820; // add $7,$6,$6
    localparam logic [31:0] ADDI8 = 32'h20080001; // addi $8,$0,1
    localparam logic [31:0] ORI8  = 32'h34080002; // ori $8,$0,2
    localparam logic [31:0] UNK   = 32'hFC000000; // unlisted opcode
    localparam logic [31:0] SLL9  = 32'h00A24900; // sll $9,$2,4 (rs field=5)
    localparam logic [31:0] ADD10 = 32'h00A55020; // add $10,$5,$5

    id_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_regA(out_regA), .out_regB(out_regB),
        .out_dest(out_dest), .out_wen(out_wen),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instruction, 32'd0);
        chk("rst_out_dest", {27'd0, out_dest}, 32'd0);
        rst = 1'b0; #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // basic issue
        wb(5'd1, 32'd7);
        wb(5'd2, 32'd3);
        in_valid = 1'b1; in_instr = ADD3; #1;
        chk("add_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_instr", out_instruction, ADD3);
        chk("add_regA", out_regA, 32'd7);
        chk("add_regB", out_regB, 32'd3);
        chk("add_dest", {27'd0, out_dest}, 32'd3);
        chk("add_wen", {31'd0, out_wen}, 32'd1);

        // RAW stall
        in_instr = ADDI4;
        tick();
        chk("addi4_dest", {27'd0, out_dest}, 32'd4);
        chk("addi4_regA", out_regA, 32'd0);
        in_instr = SUB5; #1;
        chk("raw_stall0", {31'd0, in_ready}, 32'd0);
        tick();
        chk("raw_stall1", {31'd0, in_ready}, 32'd0);
        chk("raw_drained", {31'd0, out_valid}, 32'd0);
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'd5; #1;
`ifdef ID_STAGE_BYPASS_EN
        chk("raw_wb_ready", {31'd0, in_ready}, 32'd1);
        tick();
        wb_en = 1'b0;
`else
        chk("raw_wb_ready", {31'd0, in_ready}, 32'd0);
        tick();
        wb_en = 1'b0; #1;
        chk("raw_after_wb", {31'd0, in_ready}, 32'd1);
        tick();
`endif
        chk("sub_instr", out_instruction, SUB5);
        chk("sub_regA", out_regA, 32'd5);
        chk("sub_regB", out_regB, 32'd7);
        chk("sub_dest", {27'd0, out_dest}, 32'd5);

        // backpressure
        out_ready = 1'b0; in_instr = SW12;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_instr", out_instruction, SUB5);
            chk("bp_regA", out_regA, 32'd5);
        end
        out_ready = 1'b1; #1;
        chk("bp_release", {31'd0, in_ready}, 32'd1);
        tick();
        chk("sw_instr", out_instruction, SW12);
        chk("sw_wen", {31'd0, out_wen}, 32'd0);
        chk("sw_dest", {27'd0, out_dest}, 32'd0);
        chk("sw_regA", out_regA, 32'd3);
        chk("sw_regB", out_regB, 32'd7);

        // flush
        in_instr = LW6;
        tick();
        chk("lw_dest", {27'd0, out_dest}, 32'd6);
        chk("lw_regA", out_regA, 32'd7);
        in_instr = ADD7; #1;
        chk("add7_stall", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; out_ready = 1'b0; #1;
        chk("flush_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_hold", out_instruction, LW6);
        flush = 1'b0; out_ready = 1'b1; #1;
        chk("flush_busy_clr", {31'd0, in_ready}, 32'd1);
        tick();
        chk("add7_instr", out_instruction, ADD7);
        chk("add7_dest", {27'd0, out_dest}, 32'd7);

        // zero register and WAW
        in_valid = 1'b0;
        wb(5'd0, 32'h12345678);
        in_valid = 1'b1; in_instr = ADDI8;
        tick();
        chk("r0_read", out_regA, 32'd0);
        chk("addi8_dest", {27'd0, out_dest}, 32'd8);
        in_instr = ORI8; #1;
        chk("waw_stall0", {31'd0, in_ready}, 32'd0);
        tick();
        chk("waw_stall1", {31'd0, in_ready}, 32'd0);
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'd9;
        tick();
        wb_en = 1'b0; #1;
        chk("waw_release", {31'd0, in_ready}, 32'd1);
        tick();
        chk("ori8_instr", out_instruction, ORI8);
        chk("ori8_dest", {27'd0, out_dest}, 32'd8);

        // unlisted opcode passes through without a write
        in_instr = UNK;
        tick();
        chk("unk_instr", out_instruction, UNK);
        chk("unk_wen", {31'd0, out_wen}, 32'd0);
        chk("unk_dest", {27'd0, out_dest}, 32'd0);

        // sll ignores its rs field even though $5 is busy
        in_instr = SLL9; #1;
        chk("sll_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("sll_dest", {27'd0, out_dest}, 32'd9);
        chk("sll_regB", out_regB, 32'd3);

        // reset mid-stream
        in_valid = 1'b0;
        wb(5'd5, 32'h000000AA);
        in_valid = 1'b1; in_instr = ADD10;
        tick();
        chk("pre_rst_regA", out_regA, 32'h000000AA);
        in_valid = 1'b0; rst = 1'b1; #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_regA", out_regA, 32'd0);
        chk("mid_rst_instr", out_instruction, 32'd0);
        chk("mid_rst_wen", {31'd0, out_wen}, 32'd0);
        tick();
        rst = 1'b0; in_valid = 1'b1; in_instr = ADD10; #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_r5", out_regA, 32'd0);
        in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode and operand-read stage that sits directly upstream of the execute ALU. It holds the 32×32 general register file, decodes the source and destination fields of each MIPS instruction, and tracks in-flight writes with a busy-bit scoreboard so that RAW and WAW hazards stall issue. Its output register delivers `out_instruction`, `out_regA` and `out_regB` to the ALU one cycle after an instruction is accepted, and it absorbs writebacks from the end of the pipeline.

## Interface
- `DATA_WIDTH`, 32: register and operand width; only 32 is supported.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: fetch presents `in_instr`.
- `in_ready` output 1: the stage accepts `in_instr` this cycle.
- `in_instr` input 32: instruction word from fetch.
- `out_valid` output 1: the output register holds a live instruction.
- `out_ready` input 1: the ALU/EX side consumes the output this cycle.
- `out_instruction` output 32: instruction forwarded to the ALU.
- `out_regA` output 32: GPR[instr[25:21]].
- `out_regB` output 32: GPR[instr[20:16]].
- `out_dest` output 5: destination register; 0 when there is no write.
- `out_wen` output 1: the instruction will write `out_dest`.
- `wb_en` input 1: writeback strobe.
- `wb_addr` input 5: writeback register.
- `wb_data` input 32: writeback value.
- `flush` input 1: discard the instruction held in the output register (taken branch).

## Operation
- Reset:
  - all 32 GPRs are 0 and all busy bits are 0;
  - `out_valid`=0; `out_instruction`, `out_regA`, `out_regB`, `out_dest`, `out_wen` are all 0;
  - `in_ready` is combinational and reads 1 once reset deasserts.
- Register 0:
  - always reads 0;
  - writes to it are ignored;
  - it is never marked busy.
- Destination decode:
  - opcode 000000 → rd = instr[15:11];
  - addi, addiu, andi, ori, xori, slti, sltiu, lw → rt = instr[20:16];
  - sw, beq, bne, and any unlisted opcode → no write (`out_wen`=0, `out_dest`=0).
- Source use:
  - rs is used by every instruction except R-type sll, srl, sra;
  - rt is used by R-type, sw, beq, bne.
- Hazard: asserted when any used source is busy, or when the destination is busy (WAW).
- Handshake:
  - `in_ready` = (!`out_valid` | `out_ready`) & !hazard & !`flush`.
  - Accept happens when `in_valid` & `in_ready`.
  - On accept: load the output register, read operands, and set busy[dest] if the instruction writes.
  - If there is no accept but `out_ready` is high: `out_valid`←0.
  - While `out_valid`=1 and `out_ready`=0: all outputs hold stable.
- Writeback: when `wb_en` is high and `wb_addr`≠0, GPR[`wb_addr`]←`wb_data` and busy[`wb_addr`]←0.
- Flush:
  - `out_valid`←0;
  - if `out_wen` was set, clear busy[`out_dest`];
  - no accept occurs that cycle.
- Simultaneous events:
  - If a writeback clears a register and a newly accepted instruction sets the same register in the same cycle, the set wins (busy stays 1).
  - A flush clear and a writeback clear of the same register leave it 0.
- An instruction with an unlisted opcode still passes through to the ALU with `out_wen`=0.

## Timing
- Accept-to-output latency is 1 cycle. Back-to-back accepts are possible at 1 per cycle when there is no hazard and `out_ready` is held high.
- Busy bits are registered. A dependent instruction stalls from the cycle after its producer is accepted until the producer's writeback cycle, or the cycle after it (see Configuration).
- Operand reads sample the register file in the accept cycle; the values are then held in the output register.
- `rst` asserted mid-operation immediately clears `out_valid`, all busy bits and all GPRs. Any in-flight writeback that cycle is lost.

## Configuration
- `ID_STAGE_BYPASS_EN`:
  - **Defined:** a register being written this cycle (`wb_en`, `wb_addr` matching a source) is treated as not busy, and `wb_data` is forwarded into `out_regA`/`out_regB` on accept. A dependent instruction therefore issues in the writeback cycle.
  - **Undefined:** the hazard check uses the registered busy bits only, and reads return the pre-write GPR value. A dependent instruction issues one cycle after writeback.

## Test plan
- **Reset:** assert `rst` mid-stream → `out_valid`=0, outputs 0, and after release `in_ready`=1; reading $5 returns 0.
- **Basic issue:** writeback $1=0x00000007 and $2=0x00000003, then feed `add $3,$1,$2` (0x00221820) with `out_ready`=1 → next cycle `out_valid`=1, `out_regA`=7, `out_regB`=3, `out_dest`=3, `out_wen`=1.
- **RAW stall:**
  - feed `addi $4,$0,5`, then `sub $5,$4,$1` → `in_ready`=0 until `wb_en`, `wb_addr`=4, `wb_data`=5;
  - with bypass: issue in that cycle, `out_regA`=5;
  - without bypass: issue one cycle later.
- **Backpressure:** hold `out_ready`=0 for 3 cycles with `out_valid`=1 → all outputs stable and `in_ready`=0; release → next instruction is accepted the same cycle.
- **Flush:** flush while the output register holds `lw $6,0($1)` → `out_valid`=0, busy[6] cleared, and a following `add $7,$6,$6` issues with no stall.
- **Zero register and WAW:**
  - write 0x12345678 to $0 → a read of $0 returns 0;
  - `addi $8,..`, then `ori $8,..` with no writeback → the second stalls until $8 is written back.
